// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard inputs, stage controls and status.
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_MemR;
    logic [4:0]  ex_rt;
    logic        branch_taken;
    logic        jump_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        PC_WR;
    logic        IF_ID_WR;
    logic        ID_EX_WR;
    logic        EX_MEM_WR;
    logic        IF_ID_FLUSH;
    logic        ID_EX_FLUSH;
    logic        mem_err;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_rs, id_rt, ex_MemR, ex_rt, branch_taken, jump_taken, mem_req, mem_ready,
        input  PC_WR, IF_ID_WR, ID_EX_WR, EX_MEM_WR, IF_ID_FLUSH, ID_EX_FLUSH,
        input  mem_err, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_MemR, ex_rt, branch_taken, jump_taken, mem_req, mem_ready,
        output PC_WR, IF_ID_WR, ID_EX_WR, EX_MEM_WR, IF_ID_FLUSH, ID_EX_FLUSH,
        output mem_err, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch/jump flushes,
// memory-wait freeze with timeout, and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned WAIT_MAX = 64
) (
    input logic           clk,
    input logic           rst,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam int unsigned WW = $clog2(WAIT_MAX + 1) + 1;

    state_t      r_state, w_state_nxt;
    logic [WW-1:0] r_wait, w_wait_nxt;
    logic        r_mem_err, w_mem_err_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_lu;
    logic        w_ms;
    logic        w_issue;
    int unsigned w_wait_inc;
    logic        w_pc_wr, w_ifid_wr, w_idex_wr, w_exmem_wr;
    logic        w_ifid_flush, w_idex_flush;

    // A load into r0 never produces a value worth waiting for.
    assign w_lu = hz.ex_MemR && (hz.ex_rt != '0) &&
                  ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));
    assign w_ms = hz.mem_req && !hz.mem_ready;
    assign w_wait_inc = 32'(r_wait) + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_wait    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_mem_err_nxt = r_mem_err;
        w_issue       = 1'b0;
        w_pc_wr       = 1'b0;
        w_ifid_wr     = 1'b0;
        w_idex_wr     = 1'b0;
        w_exmem_wr    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;

        case (r_state)
            RUN: begin
                if (w_ms) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = WW'(1);
                end else begin
                    w_issue = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!hz.mem_ready) begin
                    w_wait_nxt = WW'(w_wait_inc);
                    if (w_wait_inc >= WAIT_MAX) begin
                        w_state_nxt   = ERR;
                        w_mem_err_nxt = 1'b1;
                    end
                end else begin
                    w_issue     = 1'b1;
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end
            end
            ERR: begin
                w_mem_err_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase

        // Release and RUN share the same decode; branch/jump win over a load-use bubble.
        if (w_issue) begin
            w_pc_wr    = 1'b1;
            w_ifid_wr  = 1'b1;
            w_idex_wr  = 1'b1;
            w_exmem_wr = 1'b1;
            if (hz.branch_taken) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (hz.jump_taken) begin
                w_ifid_flush = 1'b1;
            end else if (w_lu) begin
                w_pc_wr      = 1'b0;
                w_ifid_wr    = 1'b0;
                w_idex_flush = 1'b1;
            end
        end

        if (rst) begin
            w_pc_wr      = 1'b0;
            w_ifid_wr    = 1'b0;
            w_idex_wr    = 1'b0;
            w_exmem_wr   = 1'b0;
            w_ifid_flush = 1'b0;
            w_idex_flush = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_wr && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign hz.PC_WR       = w_pc_wr;
    assign hz.IF_ID_WR    = w_ifid_wr;
    assign hz.ID_EX_WR    = w_idex_wr;
    assign hz.EX_MEM_WR   = w_exmem_wr;
    assign hz.IF_ID_FLUSH = w_ifid_flush;
    assign hz.ID_EX_FLUSH = w_idex_flush;
    assign hz.mem_err     = r_mem_err;
    assign hz.state       = r_state;
    assign hz.stall_cnt   = r_stall_cnt;
    assign hz.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for RUN-state decode plus
// hand-written memory-wait, timeout, reset-abort and saturation sequences.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.WAIT_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    // {PC_WR, IF_ID_WR, ID_EX_WR, EX_MEM_WR, IF_ID_FLUSH, ID_EX_FLUSH}
    localparam logic [5:0] C_NORM   = 6'b111100;
    localparam logic [5:0] C_FROZEN = 6'b000000;
    localparam logic [5:0] C_BRANCH = 6'b111111;
    localparam logic [5:0] C_JUMP   = 6'b111110;
    localparam logic [5:0] C_LU     = 6'b001101;

    typedef struct {
        logic       memr;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       mreq;
        logic       mrdy;
        logic       br;
        logic       jmp;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [12];

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    function automatic logic [5:0] ctl();
        return {hz.PC_WR, hz.IF_ID_WR, hz.ID_EX_WR, hz.EX_MEM_WR, hz.IF_ID_FLUSH, hz.ID_EX_FLUSH};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic memr, input logic [4:0] ex_rt, input logic [4:0] id_rs,
                         input logic [4:0] id_rt, input logic mreq, input logic mrdy,
                         input logic br, input logic jmp);
        hz.ex_MemR      = memr;
        hz.ex_rt        = ex_rt;
        hz.id_rs        = id_rs;
        hz.id_rt        = id_rt;
        hz.mem_req      = mreq;
        hz.mem_ready    = mrdy;
        hz.branch_taken = br;
        hz.jump_taken   = jmp;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_stall_cnt"}, 32'(hz.stall_cnt), 32'(exp_stall));
        chk({tag, "_flush_cnt"}, 32'(hz.flush_cnt), 32'(exp_flush));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_NORM,   "normal"};
        vecs[1]  = '{1'b1, 5'd5,  5'd5, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, C_LU,     "lu_rs"};
        vecs[2]  = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, C_NORM,   "lu_r0"};
        vecs[3]  = '{1'b1, 5'd7,  5'd2, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, C_LU,     "lu_rt"};
        vecs[4]  = '{1'b1, 5'd7,  5'd2, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, C_NORM,   "load_nomatch"};
        vecs[5]  = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, C_BRANCH, "branch_over_lu"};
        vecs[6]  = '{1'b0, 5'd0,  5'd1, 5'd2,  1'b0, 1'b0, 1'b0, 1'b1, C_JUMP,   "jump"};
        vecs[7]  = '{1'b1, 5'd9,  5'd9, 5'd9,  1'b0, 1'b0, 1'b0, 1'b1, C_JUMP,   "jump_over_lu"};
        vecs[8]  = '{1'b0, 5'd0,  5'd1, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, C_BRANCH, "branch_over_jump"};
        vecs[9]  = '{1'b1, 5'd4,  5'd4, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0, C_LU,     "lu_mem_ready"};
        vecs[10] = '{1'b0, 5'd5,  5'd5, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, C_NORM,   "no_load_match"};
        vecs[11] = '{1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,     "lu_r31"};

        // Outputs held off during reset even with hazards present.
        rst = 1'b1;
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_ctl", 32'(ctl()), 32'(C_FROZEN));
        tick();
        tick();
        chk("rst_state", 32'(hz.state), 32'd0);
        chk("rst_mem_err", 32'(hz.mem_err), 32'd0);
        chk_cnts("rst");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].memr, vecs[i].ex_rt, vecs[i].id_rs, vecs[i].id_rt,
                  vecs[i].mreq, vecs[i].mrdy, vecs[i].br, vecs[i].jmp);
            chk({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].exp));
            if (!vecs[i].exp[5]) exp_stall++;
            if (vecs[i].exp[1])  exp_flush++;
            tick();
            chk({vecs[i].name, "_state"}, 32'(hz.state), 32'd0);
            chk_cnts(vecs[i].name);
        end

        // Load-use bubble lasts exactly one cycle once the load moves on.
        idle();
        chk("lu_after_ctl", 32'(ctl()), 32'(C_NORM));
        tick();

        // Memory wait: three frozen cycles, release on the fourth.
        for (int c = 1; c <= 3; c++) begin
            drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("mw_c%0d_state", c), 32'(hz.state), (c == 1) ? 32'd0 : 32'd1);
            chk($sformatf("mw_c%0d_ctl", c), 32'(ctl()), 32'(C_FROZEN));
            exp_stall++;
            tick();
        end
        drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mw_rel_state", 32'(hz.state), 32'd1);
        chk("mw_rel_ctl", 32'(ctl()), 32'(C_NORM));
        tick();
        idle();
        chk("mw_after_state", 32'(hz.state), 32'd0);
        chk_cnts("mw_after");

        // Branch held through a two-cycle wait acts only in the release cycle.
        for (int c = 1; c <= 2; c++) begin
            drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("bw_c%0d_ctl", c), 32'(ctl()), 32'(C_FROZEN));
            exp_stall++;
            tick();
        end
        drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("bw_rel_ctl", 32'(ctl()), 32'(C_BRANCH));
        exp_flush++;
        tick();
        idle();
        chk("bw_after_state", 32'(hz.state), 32'd0);
        chk_cnts("bw_after");

        // Timeout with WAIT_MAX=4: error state after the fourth wait cycle.
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("to_c%0d_ctl", c), 32'(ctl()), 32'(C_FROZEN));
            chk($sformatf("to_c%0d_err", c), 32'(hz.mem_err), 32'd0);
            tick();
            chk($sformatf("to_c%0d_state", c), 32'(hz.state), (c == 4) ? 32'd2 : 32'd1);
        end
        chk("to_mem_err", 32'(hz.mem_err), 32'd1);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("err_ctl", 32'(ctl()), 32'(C_FROZEN));
        tick();
        chk("err_hold_state", 32'(hz.state), 32'd2);
        chk("err_hold_mem_err", 32'(hz.mem_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("err_rst_ctl", 32'(ctl()), 32'(C_FROZEN));
        tick();
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        idle();
        chk("err_rst_state", 32'(hz.state), 32'd0);
        chk("err_rst_mem_err", 32'(hz.mem_err), 32'd0);
        chk("err_rst_ctl_run", 32'(ctl()), 32'(C_NORM));
        chk_cnts("err_rst");

        // Reset during MEM_WAIT aborts the wait.
        drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mwr_state", 32'(hz.state), 32'd1);
        rst = 1'b1;
        #1;
        chk("mwr_rst_ctl", 32'(ctl()), 32'(C_FROZEN));
        tick();
        rst = 1'b0;
        idle();
        chk("mwr_after_state", 32'(hz.state), 32'd0);
        chk("mwr_after_ctl", 32'(ctl()), 32'(C_NORM));

        // Stall counter saturation.
        do_reset();
        drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", 32'(hz.stall_cnt), 32'hFFFE);
        tick();
        chk("sat_hit", 32'(hz.stall_cnt), 32'hFFFF);
        tick();
        tick();
        chk("sat_hold", 32'(hz.stall_cnt), 32'hFFFF);
        chk("sat_flush", 32'(hz.flush_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
